// File: rtl/game_state_manager_if.sv
// Game event bus between the game logic and the state manager.
// The master drives game events; the slave returns state and control outputs.
interface game_state_manager_if;
   logic       startOfFrame;
   logic       SingleHitPulse;
   logic [1:0] hitTileType;
   logic       endgame;
   logic       victory;
   logic       startKey;
   logic [2:0] gameState;
   logic [1:0] lives;
   logic [7:0] score;
   logic       freeze;
   logic       respawnPulse;

   modport master (
      output startOfFrame, SingleHitPulse, hitTileType,
      output endgame, victory, startKey,
      input  gameState, lives, score, freeze, respawnPulse
   );

   modport slave (
      input  startOfFrame, SingleHitPulse, hitTileType,
      input  endgame, victory, startKey,
      output gameState, lives, score, freeze, respawnPulse
   );
endinterface

// File: rtl/game_state_manager.sv
// Game flow FSM: idle/play/respawn/lost/won with lives, score and freeze.
// All outputs are registered and follow an input event by one clock.
module game_state_manager (
   input  logic                       clk,
   input  logic                       resetN,
   game_state_manager_if.slave        bus
);
   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_PLAY    = 3'b001,
      S_RESPAWN = 3'b010,
      S_LOST    = 3'b011,
      S_WON     = 3'b100
   } state_t;

   localparam logic [1:0] T_GIFT = 2'b10;
   localparam logic [1:0] T_HOLE = 2'b11;

   state_t     r_state, w_state_nxt;
   logic [1:0] r_lives, w_lives_nxt;
   logic [7:0] r_score, w_score_nxt;
   logic [5:0] r_cnt,   w_cnt_nxt;
   logic       r_freeze, w_freeze_nxt;
   logic       r_rsp,    w_rsp_nxt;
   logic       r_key_prev;
   logic       r_key_armed;
   logic       w_key_rise;
   logic       w_gift;
   logic       w_hole;

   // A key held through reset must be seen low before it can count.
   assign w_key_rise = bus.startKey & ~r_key_prev & r_key_armed;
   assign w_gift = bus.SingleHitPulse & (bus.hitTileType == T_GIFT);
   assign w_hole = bus.SingleHitPulse & (bus.hitTileType == T_HOLE);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_key_prev  <= 1'b0;
         r_key_armed <= 1'b0;
      end else begin
         r_key_prev <= bus.startKey;
         if (!bus.startKey)
            r_key_armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state  <= S_IDLE;
         r_lives  <= 2'd3;
         r_score  <= 8'd0;
         r_cnt    <= 6'd0;
         r_freeze <= 1'b1;
         r_rsp    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_lives  <= w_lives_nxt;
         r_score  <= w_score_nxt;
         r_cnt    <= w_cnt_nxt;
         r_freeze <= w_freeze_nxt;
         r_rsp    <= w_rsp_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_lives_nxt = r_lives;
      w_score_nxt = r_score;
      w_cnt_nxt   = r_cnt;
      w_rsp_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_key_rise) begin
               w_state_nxt = S_PLAY;
               w_lives_nxt = 2'd3;
               w_score_nxt = 8'd0;
            end
         end
         S_PLAY: begin
            // endgame wins over a same-cycle hit, which is dropped
            if (bus.endgame) begin
               w_state_nxt = bus.victory ? S_WON : S_LOST;
            end else if (w_gift) begin
               w_score_nxt = (r_score > 8'd245) ? 8'd255
                                                : r_score + 8'd10;
            end else if (w_hole) begin
               if (r_lives > 2'd1) begin
                  w_lives_nxt = r_lives - 2'd1;
                  w_rsp_nxt   = 1'b1;
                  w_cnt_nxt   = 6'd60;
                  w_state_nxt = S_RESPAWN;
               end else begin
                  w_lives_nxt = 2'd0;
                  w_state_nxt = S_LOST;
               end
            end
         end
         S_RESPAWN: begin
            if (r_cnt == 6'd0) begin
               w_state_nxt = S_PLAY;
            end else if (bus.startOfFrame) begin
               w_cnt_nxt = r_cnt - 6'd1;
               if (r_cnt == 6'd1)
                  w_state_nxt = S_PLAY;
            end
         end
         S_LOST, S_WON: begin
            if (w_key_rise)
               w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      w_freeze_nxt = (w_state_nxt != S_PLAY);
   end

   assign bus.gameState    = r_state;
   assign bus.lives        = r_lives;
   assign bus.score        = r_score;
   assign bus.freeze       = r_freeze;
   assign bus.respawnPulse = r_rsp;
endmodule

// File: tb/tb_game_state_manager.sv
// Directed bench for game_state_manager with hand-computed expectations.
// Inputs change just after negedge; outputs are sampled at negedge.
module tb_game_state_manager;
   logic clk;
   logic resetN;
   int   n_cmp;
   int   n_err;

   game_state_manager_if bus ();

   game_state_manager dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic hit(input logic [1:0] t);
      bus.SingleHitPulse = 1'b1;
      bus.hitTileType    = t;
      step();
      bus.SingleHitPulse = 1'b0;
      bus.hitTileType    = 2'b00;
   endtask

   task automatic sof(input int n);
      for (int i = 0; i < n; i++) begin
         bus.startOfFrame = 1'b1;
         step();
         bus.startOfFrame = 1'b0;
         step();
      end
   endtask

   task automatic key_press();
      bus.startKey = 1'b1;
      step();
   endtask

   task automatic key_release();
      bus.startKey = 1'b0;
      step();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      resetN = 1'b0;
      bus.startOfFrame   = 1'b0;
      bus.SingleHitPulse = 1'b0;
      bus.hitTileType    = 2'b00;
      bus.endgame        = 1'b0;
      bus.victory        = 1'b0;
      bus.startKey       = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state",  bus.gameState, 0);
      chk("rst_lives",  bus.lives, 3);
      chk("rst_score",  bus.score, 0);
      chk("rst_freeze", bus.freeze, 1);
      chk("rst_rsp",    bus.respawnPulse, 0);
      resetN = 1'b1;
      step();
      chk("idle_hold", bus.gameState, 0);

      key_press();
      chk("start_state",  bus.gameState, 1);
      chk("start_lives",  bus.lives, 3);
      chk("start_score",  bus.score, 0);
      chk("start_freeze", bus.freeze, 0);
      step();
      chk("key_level", bus.gameState, 1);
      key_release();

      for (int i = 0; i < 25; i++) begin
         hit(2'b10);
         step();
      end
      chk("score_250", bus.score, 250);
      hit(2'b10);
      chk("score_sat", bus.score, 255);
      hit(2'b00);
      hit(2'b01);
      chk("bg_floor_score", bus.score, 255);
      chk("bg_floor_lives", bus.lives, 3);
      key_press();
      chk("key_in_play", bus.gameState, 1);
      key_release();

      hit(2'b11);
      chk("hole_lives",  bus.lives, 2);
      chk("hole_rsp",    bus.respawnPulse, 1);
      chk("hole_state",  bus.gameState, 2);
      chk("hole_freeze", bus.freeze, 1);
      step();
      chk("rsp_one_cyc", bus.respawnPulse, 0);
      hit(2'b11);
      bus.endgame = 1'b1;
      step();
      bus.endgame = 1'b0;
      chk("rsp_ign_lives", bus.lives, 2);
      chk("rsp_ign_state", bus.gameState, 2);
      sof(59);
      chk("rsp_59", bus.gameState, 2);
      sof(1);
      chk("rsp_60_state",  bus.gameState, 1);
      chk("rsp_60_freeze", bus.freeze, 0);

      hit(2'b11);
      chk("hole2_lives", bus.lives, 1);
      sof(60);
      chk("play_again", bus.gameState, 1);
      hit(2'b11);
      chk("last_lives", bus.lives, 0);
      chk("last_state", bus.gameState, 3);
      chk("last_rsp",   bus.respawnPulse, 0);
      key_press();
      chk("lost_to_idle", bus.gameState, 0);
      key_release();

      key_press();
      key_release();
      hit(2'b10);
      chk("gift_10", bus.score, 10);
      bus.endgame = 1'b1;
      bus.victory = 1'b1;
      hit(2'b10);
      bus.endgame = 1'b0;
      bus.victory = 1'b0;
      chk("won_state", bus.gameState, 4);
      chk("won_score", bus.score, 10);
      chk("won_freeze", bus.freeze, 1);
      key_press();
      chk("won_to_idle", bus.gameState, 0);
      key_release();

      key_press();
      key_release();
      bus.endgame = 1'b1;
      step();
      bus.endgame = 1'b0;
      chk("loss_eg", bus.gameState, 3);
      chk("loss_lives", bus.lives, 3);
      key_press();
      key_release();

      key_press();
      key_release();
      hit(2'b10);
      hit(2'b11);
      sof(5);
      chk("pre_rst", bus.gameState, 2);
      #2;
      resetN = 1'b0;
      #1;
      chk("mid_rst_state",  bus.gameState, 0);
      chk("mid_rst_lives",  bus.lives, 3);
      chk("mid_rst_score",  bus.score, 0);
      chk("mid_rst_freeze", bus.freeze, 1);
      bus.startKey = 1'b1;
      @(negedge clk);
      resetN = 1'b1;
      step();
      chk("post_rst_rsp", bus.respawnPulse, 0);
      step();
      chk("held_key", bus.gameState, 0);
      key_release();
      key_press();
      chk("rearm_key", bus.gameState, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
